// File: rtl/core_pkg.sv
// Shared definitions for the multicycle RV32I-subset core controller:
// FSM state encoding, opcode constants and datapath select encodings.
package core_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_BRANCH,
    S_JAL,
    S_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALU_OUT  = 2'b00;
  localparam logic [1:0] RES_MEM_DATA = 2'b01;
  localparam logic [1:0] RES_ALU_LIVE = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode/funct classifier: picks the state that follows
// DECODE and tells MEM_ADDR whether the access is a store.
module instr_decode
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output state_t     decode_next,
  output logic       is_store
);

  // Classify the instruction; any unsupported encoding maps to ILLEGAL.
  always_comb begin
    decode_next = S_ILLEGAL;
    is_store    = (opcode == OP_STORE);
    case (opcode)
      OP_R:      if (funct3 == 3'b000 && funct7 == 7'b0000000) decode_next = S_EXEC_R;
      OP_I:      if (funct3 == 3'b000) decode_next = S_EXEC_I;
      OP_LOAD,
      OP_STORE:  if (funct3 == 3'b010) decode_next = S_MEM_ADDR;
      OP_BRANCH: if (funct3 == 3'b000) decode_next = S_BRANCH;
      OP_JAL:    decode_next = S_JAL;
      default:   decode_next = S_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle sequencer for the ADD/ADDI/BEQ/JAL/SW/LW core: drives PC, IR,
// register file, shared ALU and the unified memory port, counts retirements.
module multicycle_controller
  import core_pkg::*;
#(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_control,
  output logic [1:0]           result_src,
  output logic                 reg_write,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  state_t state;
  state_t state_next;
  state_t decode_next;
  logic   is_store;
  logic   retire;

  instr_decode u_decode (
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .decode_next (decode_next),
    .is_store    (is_store)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  // Next-state logic; memory states wait for mem_ready.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:     if (mem_ready) state_next = S_DECODE;
      S_DECODE:    state_next = decode_next;
      S_EXEC_R:    state_next = S_ALU_WB;
      S_EXEC_I:    state_next = S_ALU_WB;
      S_ALU_WB:    state_next = S_FETCH;
      S_MEM_ADDR:  state_next = is_store ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_next = S_MEM_WB;
      S_MEM_WB:    state_next = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_next = S_FETCH;
      S_BRANCH:    state_next = S_FETCH;
      S_JAL:       state_next = S_ALU_WB;
      S_ILLEGAL:   state_next = S_FETCH;
      default:     state_next = S_FETCH;
    endcase
  end

  // Output decode; gated by rst_n so outputs clear the moment reset asserts,
  // which also abandons any in-flight memory request.
  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_RS2;
    alu_control = ALU_ADD;
    result_src  = RES_ALU_OUT;
    reg_write   = 1'b0;
    illegal     = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_a  = SRC_A_PC;
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALU_LIVE;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
        end
        S_EXEC_R: begin
          alu_src_a   = SRC_A_RS1;
          alu_src_b   = SRC_B_RS2;
          alu_control = ALU_ADD;
        end
        S_EXEC_I, S_MEM_ADDR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
        end
        S_ALU_WB: begin
          reg_write  = 1'b1;
          result_src = RES_ALU_OUT;
        end
        S_MEM_READ: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          result_src = RES_MEM_DATA;
        end
        S_MEM_WRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a   = SRC_A_RS1;
          alu_src_b   = SRC_B_RS2;
          alu_control = ALU_SUB;
          result_src  = RES_ALU_OUT;
          pc_write    = zero;
        end
        S_JAL: begin
          alu_src_a  = SRC_A_OLD_PC;
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALU_OUT;
          pc_write   = 1'b1;
        end
        S_ILLEGAL: illegal = 1'b1;
        default: ;
      endcase
    end
  end

  // An instruction retires on its final cycle; JAL retires via ALU_WB only.
  always_comb begin
    retire = 1'b0;
    case (state)
      S_ALU_WB, S_MEM_WB, S_BRANCH: retire = 1'b1;
      S_MEM_WRITE:                  retire = mem_ready;
      default:                      retire = 1'b0;
    endcase
  end

  // Retired-instruction counter, wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret <= '0;
    else if (retire) instret <= instret + INSTRET_W'(1);
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the stimulus process pushes the
// expected per-cycle control word, a monitor pops and compares on the falling edge.
module tb_multicycle_controller;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_control;
    logic [1:0] result_src;
    logic       reg_write;
    logic       illegal;
    logic [3:0] instret;
  } ctl_t;

  typedef struct {
    ctl_t  word;
    string tag;
  } exp_t;

  typedef enum {P_RST, P_F, P_D, P_ER, P_EI, P_AW, P_MA, P_MR, P_MW, P_MWR, P_BR, P_J, P_IL} phase_t;
  typedef enum {K_R, K_I, K_LOAD, K_STORE, K_BR, K_JAL, K_ILL} kind_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, alu_control, result_src;
  logic [3:0] instret;

  exp_t       sb[$];
  logic [3:0] exp_instret;
  int         checks = 0;
  int         failures = 0;
  logic       stim_done = 1'b0;

  multicycle_controller #(.INSTRET_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_write   (mem_write),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .result_src  (result_src),
    .reg_write   (reg_write),
    .illegal     (illegal),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  // Expected control word for one cycle in a given phase.
  function automatic ctl_t exp_word(input phase_t ph, input logic rdy, input logic z, input logic [3:0] cnt);
    ctl_t w;
    w = '0;
    w.instret = cnt;
    case (ph)
      P_F:   begin w.mem_req = 1'b1; w.alu_src_b = 2'b10; w.result_src = 2'b10;
                   w.ir_write = rdy; w.pc_write = rdy; end
      P_D:   begin w.alu_src_a = 2'b01; w.alu_src_b = 2'b01; end
      P_ER:  begin w.alu_src_a = 2'b10; w.alu_src_b = 2'b00; end
      P_EI:  begin w.alu_src_a = 2'b10; w.alu_src_b = 2'b01; end
      P_AW:  begin w.reg_write = 1'b1; w.result_src = 2'b00; end
      P_MA:  begin w.alu_src_a = 2'b10; w.alu_src_b = 2'b01; end
      P_MR:  begin w.mem_req = 1'b1; w.adr_src = 1'b1; end
      P_MW:  begin w.reg_write = 1'b1; w.result_src = 2'b01; end
      P_MWR: begin w.mem_req = 1'b1; w.mem_write = 1'b1; w.adr_src = 1'b1; end
      P_BR:  begin w.alu_src_a = 2'b10; w.alu_control = 2'b01; w.pc_write = z; end
      P_J:   begin w.alu_src_a = 2'b01; w.alu_src_b = 2'b10; w.pc_write = 1'b1; end
      P_IL:  w.illegal = 1'b1;
      default: w = '0;
    endcase
    return w;
  endfunction

  // One clock cycle of stimulus: drive inputs, queue the expectation, advance.
  task automatic cyc(input phase_t ph, input logic rdy);
    exp_t e;
    rst_n     = (ph != P_RST);
    mem_ready = rdy;
    if (ph == P_RST) exp_instret = '0;
    e.word = exp_word(ph, rdy, zero, exp_instret);
    e.tag  = ph.name();
    sb.push_back(e);
    if (ph == P_AW || ph == P_MW || ph == P_BR || (ph == P_MWR && rdy)) exp_instret++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [31:0] ir, input kind_t k, input int fw, input int mw, input logic z);
    opcode = ir[6:0];
    funct3 = ir[14:12];
    funct7 = ir[31:25];
    zero   = z;
    repeat (fw) cyc(P_F, 1'b0);
    cyc(P_F, 1'b1);
    cyc(P_D, 1'b0);
    case (k)
      K_R:     begin cyc(P_ER, 1'b0); cyc(P_AW, 1'b0); end
      K_I:     begin cyc(P_EI, 1'b0); cyc(P_AW, 1'b0); end
      K_LOAD:  begin cyc(P_MA, 1'b0); repeat (mw) cyc(P_MR, 1'b0);
                     cyc(P_MR, 1'b1); cyc(P_MW, 1'b0); end
      K_STORE: begin cyc(P_MA, 1'b0); repeat (mw) cyc(P_MWR, 1'b0);
                     cyc(P_MWR, 1'b1); end
      K_BR:    cyc(P_BR, 1'b0);
      K_JAL:   begin cyc(P_J, 1'b0); cyc(P_AW, 1'b0); end
      K_ILL:   cyc(P_IL, 1'b0);
      default: ;
    endcase
  endtask

  // Monitor: compare DUT outputs against the scoreboard head mid-cycle.
  always @(negedge clk) begin
    ctl_t act;
    exp_t e;
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      act = {mem_req, mem_write, adr_src, ir_write, pc_write, alu_src_a, alu_src_b,
             alu_control, result_src, reg_write, illegal, instret};
      checks++;
      if (act !== e.word) begin
        failures++;
        $display("FAIL %s at %0t: actual=%b required=%b", e.tag, $time, act, e.word);
      end
    end
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0;
    opcode = '0; funct3 = '0; funct7 = '0; exp_instret = '0;
    @(posedge clk); #1;
    cyc(P_RST, 1'b1);
    cyc(P_RST, 1'b0);
    run_instr(32'h00500093, K_I,     0, 0, 1'b0);  // ADDI, 4 cycles
    run_instr(32'h002081B3, K_R,     3, 0, 1'b0);  // ADD, 3 fetch waits
    run_instr(32'h00402103, K_LOAD,  0, 0, 1'b0);  // LW
    run_instr(32'h00202423, K_STORE, 0, 0, 1'b0);  // SW
    run_instr(32'h00202423, K_STORE, 1, 2, 1'b0);  // SW with waits
    run_instr(32'h00000463, K_BR,    0, 0, 1'b1);  // BEQ taken
    run_instr(32'h00000463, K_BR,    0, 0, 1'b0);  // BEQ not taken
    run_instr(32'h010000EF, K_JAL,   0, 0, 1'b0);  // JAL
    run_instr(32'h0000707F, K_ILL,   0, 0, 1'b0);  // illegal opcode
    run_instr(32'h0000F0B3, K_ILL,   0, 0, 1'b0);  // R-type funct3!=0
    run_instr(32'h4000_00B3, K_ILL,  0, 0, 1'b0);  // R-type funct7!=0
    // Reset in the middle of a load's memory wait; mem_ready during reset is ignored.
    opcode = 7'b0000011; funct3 = 3'b010; funct7 = '0;
    cyc(P_F, 1'b1);
    cyc(P_D, 1'b0);
    cyc(P_MA, 1'b0);
    cyc(P_MR, 1'b0);
    cyc(P_RST, 1'b1);
    run_instr(32'h00402103, K_LOAD,  0, 1, 1'b0);  // restart from FETCH
    // Fifteen more ADDIs after the LW makes 16 retirements: 4-bit counter wraps.
    for (int i = 0; i < 15; i++) run_instr(32'h00500093, K_I, 0, 0, 1'b0);
    run_instr(32'h00500093, K_I, 0, 0, 1'b0);
    stim_done = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: actual=%0d entries required=0", sb.size());
    end
    checks++;
    if (instret !== 4'd1) begin
      failures++;
      $display("FAIL instret_wrap: actual=%0d required=1", instret);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    if (!stim_done) begin
      $display("FAIL watchdog: actual=timeout required=completion");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
    end
  end

endmodule
